// File: rtl/rs_err_correct.sv
// Final RS(544,514) decoder stage: applies Forney's (position, magnitude) list to the
// buffered codeword popped from the show-ahead FIFO and streams the corrected symbols out.
module rs_err_correct #(
    parameter int DATA_WIDTH = 10,
    parameter int N_SYM      = 544,
    parameter int T_MAX      = 15,
    parameter int POS_WIDTH  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pull_o,
    input  logic                  err_valid_i,
    input  logic [POS_WIDTH-1:0]  err_pos_i,
    input  logic [DATA_WIDTH-1:0] err_mag_i,
    input  logic                  err_last_i,
    output logic                  err_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_sop_o,
    output logic                  out_eop_o,
    output logic                  out_fail_o,
    input  logic                  out_ready_i
);

    localparam int IDX_W      = $clog2(T_MAX + 1);
    localparam int LIST_DEPTH = 1 << IDX_W;
    localparam logic [POS_WIDTH-1:0] LAST_SYM  = POS_WIDTH'(N_SYM - 1);
    localparam logic [IDX_W-1:0]     T_MAX_IDX = IDX_W'(T_MAX);

    typedef enum logic {
        S_LOAD,
        S_STREAM
    } state_e;

    state_e state_q, state_d;

    logic [POS_WIDTH-1:0]  posList_q [LIST_DEPTH];
    logic [DATA_WIDTH-1:0] magList_q [LIST_DEPTH];

    logic [IDX_W-1:0]      wrIdx_q, wrIdx_d;
    logic [IDX_W-1:0]      rdIdx_q, rdIdx_d;
    logic [POS_WIDTH-1:0]  symCnt_q, symCnt_d;
    logic [POS_WIDTH-1:0]  lastPos_q, lastPos_d;
    logic                  fail_q, fail_d;

    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic                  outSop_q, outSop_d;
    logic                  outEop_q, outEop_d;
    logic                  outFail_q, outFail_d;

    logic                  listWe;
    logic                  pull;
    logic                  match;
    logic [DATA_WIDTH-1:0] corr;

    // The list is consumed in ascending order, so only the head entry can match.
    assign match = !fail_q && (rdIdx_q < wrIdx_q) && (posList_q[rdIdx_q] == symCnt_q);
    assign corr  = match ? magList_q[rdIdx_q] : '0;

    always_comb begin
        state_d    = state_q;
        wrIdx_d    = wrIdx_q;
        rdIdx_d    = rdIdx_q;
        symCnt_d   = symCnt_q;
        lastPos_d  = lastPos_q;
        fail_d     = fail_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSop_d   = outSop_q;
        outEop_d   = outEop_q;
        outFail_d  = outFail_q;
        listWe     = 1'b0;
        pull       = 1'b0;

        if (outValid_q && out_ready_i) begin
            outValid_d = 1'b0;
        end

        unique case (state_q)
            S_LOAD: begin
                if (err_valid_i) begin
                    if (wrIdx_q == T_MAX_IDX) begin
                        fail_d = 1'b1;
                    end else begin
                        listWe  = 1'b1;
                        wrIdx_d = wrIdx_q + 1'b1;
                    end
                    if (err_pos_i > LAST_SYM) begin
                        fail_d = 1'b1;
                    end
                    if ((wrIdx_q != '0) && (err_pos_i <= lastPos_q)) begin
                        fail_d = 1'b1;
                    end
                    lastPos_d = err_pos_i;
                    if (err_last_i) begin
                        state_d  = S_STREAM;
                        symCnt_d = '0;
                        rdIdx_d  = '0;
                    end
                end
            end
            S_STREAM: begin
                pull = !fifo_empty_i && (!outValid_q || out_ready_i);
                if (pull) begin
                    outValid_d = 1'b1;
                    outData_d  = fifo_data_i ^ corr;
                    outSop_d   = (symCnt_q == '0);
                    outEop_d   = (symCnt_q == LAST_SYM);
                    outFail_d  = fail_q;
                    if (match) begin
                        rdIdx_d = rdIdx_q + 1'b1;
                    end
                    if (symCnt_q == LAST_SYM) begin
                        state_d = S_LOAD;
                        wrIdx_d = '0;
                        fail_d  = 1'b0;
                    end else begin
                        symCnt_d = symCnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_LOAD;
            wrIdx_q    <= '0;
            rdIdx_q    <= '0;
            symCnt_q   <= '0;
            lastPos_q  <= '0;
            fail_q     <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b0;
            outFail_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrIdx_q    <= wrIdx_d;
            rdIdx_q    <= rdIdx_d;
            symCnt_q   <= symCnt_d;
            lastPos_q  <= lastPos_d;
            fail_q     <= fail_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSop_q   <= outSop_d;
            outEop_q   <= outEop_d;
            outFail_q  <= outFail_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LIST_DEPTH; i++) begin
                posList_q[i] <= '0;
                magList_q[i] <= '0;
            end
        end else if (listWe) begin
            posList_q[wrIdx_q] <= err_pos_i;
            magList_q[wrIdx_q] <= err_mag_i;
        end
    end

    assign fifo_pull_o = pull;
    assign err_ready_o = (state_q == S_LOAD);
    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign out_sop_o   = outSop_q;
    assign out_eop_o   = outEop_q;
    assign out_fail_o  = outFail_q;

endmodule

// File: tb/tb_rs_err_correct.sv
// Bench for rs_err_correct: FIFO/downstream models drive the DUT, a scoreboard queue
// holds symbols predicted from each codeword's error list and a monitor compares them.
module tb_rs_err_correct;

    localparam int DW     = 10;
    localparam int NSYM   = 544;
    localparam int TMAX   = 15;
    localparam int PW     = 10;
    localparam int BUDGET = 20000;

    logic          clk;
    logic          rst_ni;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_pull_o;
    logic          err_valid_i;
    logic [PW-1:0] err_pos_i;
    logic [DW-1:0] err_mag_i;
    logic          err_last_i;
    logic          err_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_sop_o;
    logic          out_eop_o;
    logic          out_fail_o;
    logic          out_ready_i;

    int total = 0;
    int bad   = 0;
    int seen  = 0;
    logic randomMode = 1'b0;

    logic [DW-1:0] fifoQ [$];
    logic [12:0]   sbQ [$];

    rs_err_correct #(
        .DATA_WIDTH(DW), .N_SYM(NSYM), .T_MAX(TMAX), .POS_WIDTH(PW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_pull_o(fifo_pull_o),
        .err_valid_i(err_valid_i), .err_pos_i(err_pos_i), .err_mag_i(err_mag_i),
        .err_last_i(err_last_i), .err_ready_o(err_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_sop_o(out_sop_o),
        .out_eop_o(out_eop_o), .out_fail_o(out_fail_o), .out_ready_i(out_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Show-ahead FIFO and downstream-ready model; inputs only change 1ns after the edge.
    initial begin : fifoModel
        logic pullS, emptyS, gap;
        fifo_empty_i = 1'b1;
        fifo_data_i  = '0;
        out_ready_i  = 1'b0;
        forever begin
            @(negedge clk);
            pullS  = fifo_pull_o;
            emptyS = fifo_empty_i;
            @(posedge clk);
            #1;
            if (pullS) begin
                checkOutput("pull_when_empty", {31'd0, emptyS}, 32'd0);
                if (fifoQ.size() > 0) void'(fifoQ.pop_front());
            end
            gap          = randomMode && ($urandom_range(3) == 0);
            out_ready_i  = randomMode ? 1'($urandom_range(1)) : 1'b1;
            fifo_empty_i = gap || (fifoQ.size() == 0);
            fifo_data_i  = (fifoQ.size() > 0) ? fifoQ[0] : '0;
        end
    end

    // Monitor: pops the scoreboard on every accepted symbol, checks stability while stalled.
    initial begin : monitor
        logic        held;
        logic [12:0] heldVal;
        logic [12:0] exp;
        held = 1'b0;
        heldVal = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checkOutput("stall_stable", {out_valid_o, out_fail_o, out_sop_o, out_eop_o, out_data_o},
                                {1'b1, heldVal});
                end
                if (out_valid_o && out_ready_i) begin
                    if (sbQ.size() == 0) begin
                        failNow("unexpected_symbol");
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("sym", {out_fail_o, out_sop_o, out_eop_o, out_data_o}, exp);
                    end
                    seen++;
                    held = 1'b0;
                end else if (out_valid_o) begin
                    held    = 1'b1;
                    heldVal = {out_fail_o, out_sop_o, out_eop_o, out_data_o};
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic sendList(input logic [PW-1:0] ePos[$], input logic [DW-1:0] eMag[$]);
        bit accepted;
        int cycles;
        for (int i = 0; i < ePos.size(); i++) begin
            err_valid_i = 1'b1;
            err_pos_i   = ePos[i];
            err_mag_i   = eMag[i];
            err_last_i  = (i == ePos.size() - 1);
            accepted = 1'b0;
            cycles   = 0;
            while (!accepted && cycles < BUDGET) begin
                @(negedge clk);
                accepted = err_ready_o;
                @(posedge clk);
                #1;
                cycles++;
            end
            if (!accepted) begin
                failNow("err_accept_timeout");
                break;
            end
        end
        err_valid_i = 1'b0;
        err_last_i  = 1'b0;
    endtask

    // Predicts the whole codeword from the list rules, queues data into the FIFO, sends the list.
    task automatic applyStimulus(input logic [DW-1:0] data[$], input logic [PW-1:0] ePos[$],
                                 input logic [DW-1:0] eMag[$]);
        bit fail;
        logic [DW-1:0] corr;
        fail = (ePos.size() > TMAX);
        for (int i = 0; i < ePos.size(); i++) begin
            if (int'(ePos[i]) >= NSYM) fail = 1'b1;
            if (i > 0 && ePos[i] <= ePos[i-1]) fail = 1'b1;
        end
        for (int k = 0; k < NSYM; k++) begin
            corr = '0;
            if (!fail) begin
                for (int i = 0; i < ePos.size(); i++) begin
                    if (int'(ePos[i]) == k) corr = eMag[i];
                end
            end
            sbQ.push_back({fail, (k == 0), (k == NSYM - 1), data[k] ^ corr});
            fifoQ.push_back(data[k]);
        end
        sendList(ePos, eMag);
    endtask

    task automatic drain();
        int c = 0;
        while (sbQ.size() > 0 && c < BUDGET) begin
            @(posedge clk);
            c++;
        end
        if (sbQ.size() > 0) failNow("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic randData(output logic [DW-1:0] d[$]);
        d = {};
        for (int k = 0; k < NSYM; k++) d.push_back(DW'($urandom_range(1023)));
    endtask

    task automatic randList(input int n, output logic [PW-1:0] p[$], output logic [DW-1:0] m[$]);
        bit used [NSYM];
        int placed = 0;
        p = {};
        m = {};
        for (int k = 0; k < NSYM; k++) used[k] = 1'b0;
        while (placed < n) begin
            int r = $urandom_range(NSYM - 1);
            if (!used[r]) begin
                used[r] = 1'b1;
                placed++;
            end
        end
        for (int k = 0; k < NSYM; k++) begin
            if (used[k]) begin
                p.push_back(PW'(k));
                m.push_back(DW'($urandom_range(1, 1023)));
            end
        end
    endtask

    initial begin : mainSeq
        logic [DW-1:0] dq[$];
        logic [PW-1:0] pq[$];
        logic [DW-1:0] mq[$];
        logic [PW-1:0] tmp;
        int target, c;

        rst_ni      = 1'b0;
        err_valid_i = 1'b0;
        err_pos_i   = '0;
        err_mag_i   = '0;
        err_last_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("rst_out_data", {22'd0, out_data_o}, 32'd0);
        checkOutput("rst_flags", {29'd0, out_sop_o, out_eop_o, out_fail_o}, 32'd0);
        checkOutput("rst_pull", {31'd0, fifo_pull_o}, 32'd0);
        checkOutput("rst_err_ready", {31'd0, err_ready_o}, 32'd1);
        @(posedge clk);
        #3;
        rst_ni = 1'b1;

        $display("[TB] T1 zero errors");
        dq = {};
        for (int k = 0; k < NSYM; k++) dq.push_back(DW'(k));
        pq = {PW'(0)};
        mq = {DW'(0)};
        applyStimulus(dq, pq, mq);

        $display("[TB] T2 fifteen errors");
        randData(dq);
        pq = {PW'(0), PW'(1)};
        for (int i = 2; i < 14; i++) pq.push_back(PW'(38 * (i - 1)));
        pq.push_back(PW'(543));
        mq = {};
        for (int i = 0; i < 15; i++) mq.push_back(DW'(10'h3FF));
        applyStimulus(dq, pq, mq);

        $display("[TB] T3 sixteen entries then clean codeword");
        randData(dq);
        pq = {};
        mq = {};
        for (int i = 0; i < 16; i++) begin
            pq.push_back(PW'(30 * i));
            mq.push_back(DW'(10'h155));
        end
        applyStimulus(dq, pq, mq);
        randData(dq);
        randList(6, pq, mq);
        applyStimulus(dq, pq, mq);

        $display("[TB] T4 unsorted list and out-of-range position");
        randData(dq);
        pq = {PW'(10), PW'(5)};
        mq = {DW'(10'h0AA), DW'(10'h055)};
        applyStimulus(dq, pq, mq);
        randData(dq);
        pq = {PW'(544)};
        mq = {DW'(10'h3C3)};
        applyStimulus(dq, pq, mq);
        drain();

        $display("[TB] T6 reset mid-codeword");
        randData(dq);
        randList(4, pq, mq);
        applyStimulus(dq, pq, mq);
        target = seen + 200;
        c = 0;
        while (seen < target && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        if (seen < target) failNow("t6_wait_timeout");
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_out_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("t6_out_data", {22'd0, out_data_o}, 32'd0);
        checkOutput("t6_flags", {29'd0, out_sop_o, out_eop_o, out_fail_o}, 32'd0);
        checkOutput("t6_err_ready", {31'd0, err_ready_o}, 32'd1);
        sbQ.delete();
        fifoQ.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_ni = 1'b1;
        randData(dq);
        randList(9, pq, mq);
        applyStimulus(dq, pq, mq);
        drain();

        $display("[TB] T5 random backpressure and FIFO gaps");
        randomMode = 1'b1;
        for (int cw = 0; cw < 8; cw++) begin
            randData(dq);
            if (cw == 3) begin
                randList(16, pq, mq);
            end else if (cw == 7) begin
                randList(5, pq, mq);
                tmp   = pq[1];
                pq[1] = pq[2];
                pq[2] = tmp;
            end else if (cw == 0) begin
                pq = {PW'(0)};
                mq = {DW'(0)};
            end else begin
                randList($urandom_range(1, TMAX), pq, mq);
            end
            applyStimulus(dq, pq, mq);
        end
        drain();
        randomMode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("fifo_leftover", fifoQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
